// File: rtl/ysyx_25060170_pipe_ctrl_if.sv
// Hazard/redirect control bundle between the pipeline stages and the pipe controller.
// The master modport is the controller side and the slave modport is the pipeline side.
interface ysyx_25060170_pipe_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int PC_W   = 32
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic              id_rs1_en;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs2_en;
    logic              ex_valid;
    logic              ex_is_load;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_redirect;
    logic [PC_W-1:0]   ex_target;
    logic              ls_busy;
    logic              ls_redirect;
    logic [PC_W-1:0]   ls_target;
    logic              wb_load_valid;
    logic [REG_AW-1:0] wb_rd;
    logic              if_redirect_ready;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_target;
    logic              id_stall;
    logic              ex_stall;
    logic              ls_stall;
    logic              id_flush;
    logic              ie_flush;
    logic              ls_flush;

    modport master (
        input  id_valid, id_rs1, id_rs1_en, id_rs2, id_rs2_en,
        input  ex_valid, ex_is_load, ex_rd, ex_redirect, ex_target,
        input  ls_busy, ls_redirect, ls_target,
        input  wb_load_valid, wb_rd, if_redirect_ready,
        output redirect_valid, redirect_target,
        output id_stall, ex_stall, ls_stall,
        output id_flush, ie_flush, ls_flush
    );

    modport slave (
        output id_valid, id_rs1, id_rs1_en, id_rs2, id_rs2_en,
        output ex_valid, ex_is_load, ex_rd, ex_redirect, ex_target,
        output ls_busy, ls_redirect, ls_target,
        output wb_load_valid, wb_rd, if_redirect_ready,
        input  redirect_valid, redirect_target,
        input  id_stall, ex_stall, ls_stall,
        input  id_flush, ie_flush, ls_flush
    );
endinterface

// File: rtl/ysyx_25060170_pipe_ctrl.sv
// Hazard and redirect controller: load-use scoreboard, stall/flush generation, redirect handshake.
// Optional performance counters are enabled with `define YSYX_25060170_PIPE_PERF_EN.
module ysyx_25060170_pipe_ctrl #(
    parameter int REG_NUM = 32,
    parameter int REG_AW  = 5,
    parameter int PC_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    ysyx_25060170_pipe_ctrl_if.master   bus
`ifdef YSYX_25060170_PIPE_PERF_EN
    ,
    output logic [31:0]                 perf_stall_cnt,
    output logic [31:0]                 perf_loaduse_cnt,
    output logic [31:0]                 perf_redirect_cnt
`endif
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    state_t             state_r;
    logic [PC_W-1:0]    tgt_r;
    logic [REG_NUM-1:0] pend_r;

    logic [REG_NUM-1:0] clr_mask_s;
    logic [REG_NUM-1:0] set_mask_s;
    logic [REG_NUM-1:0] pend_eff_s;
    logic               ex_load_s;
    logic               haz_rs1_s;
    logic               haz_rs2_s;
    logic               loaduse_s;
    logic               ex_redir_s;
    logic               redir_event_s;
    logic [PC_W-1:0]    sel_target_s;
    logic               redirect_valid_s;
    logic [PC_W-1:0]    redirect_target_s;
    logic               id_stall_s;
    logic               ex_stall_s;
    logic               ls_stall_s;
    logic               id_flush_s;
    logic               ie_flush_s;
    logic               ls_flush_s;

    // x0 is hard-wired to zero, so it never gets a scoreboard bit.
    function automatic logic [REG_NUM-1:0] reg_mask(input logic [REG_AW-1:0] idx);
        logic [REG_NUM-1:0] m;
        m = '0;
        if (idx != '0) begin
            m[idx] = 1'b1;
        end else begin
            m = '0;
        end
        return m;
    endfunction

    // Load-use detection against the scoreboard with the WB bypass folded in.
    always_comb begin
        clr_mask_s = '0;
        if (bus.wb_load_valid) begin
            clr_mask_s = reg_mask(bus.wb_rd);
        end else begin
            clr_mask_s = '0;
        end
        pend_eff_s = pend_r & ~clr_mask_s;
        ex_load_s  = bus.ex_valid & bus.ex_is_load;
        haz_rs1_s  = bus.id_valid & bus.id_rs1_en & (bus.id_rs1 != '0) &
                     (pend_eff_s[bus.id_rs1] | (ex_load_s & (bus.ex_rd == bus.id_rs1)));
        haz_rs2_s  = bus.id_valid & bus.id_rs2_en & (bus.id_rs2 != '0) &
                     (pend_eff_s[bus.id_rs2] | (ex_load_s & (bus.ex_rd == bus.id_rs2)));
        loaduse_s  = haz_rs1_s | haz_rs2_s;
    end

    // Stall/flush priority and redirect request generation.
    always_comb begin
        id_stall_s        = 1'b0;
        ex_stall_s        = 1'b0;
        ls_stall_s        = 1'b0;
        id_flush_s        = 1'b0;
        ie_flush_s        = 1'b0;
        ls_flush_s        = 1'b0;
        redirect_valid_s  = 1'b0;
        redirect_target_s = '0;
        // A frozen EX cannot redirect, and a pending request masks any new EX redirect.
        ex_redir_s        = bus.ex_redirect & ~bus.ls_busy & (state_r == IDLE);
        redir_event_s     = bus.ls_redirect | ex_redir_s;
        sel_target_s      = bus.ls_redirect ? bus.ls_target : bus.ex_target;
        if (rst) begin
            redirect_valid_s = 1'b0;
        end else begin
            if (bus.ls_redirect) begin
                id_flush_s = 1'b1;
                ie_flush_s = 1'b1;
                ls_flush_s = 1'b1;
            end else if (bus.ls_busy) begin
                id_stall_s = 1'b1;
                ex_stall_s = 1'b1;
                ls_stall_s = 1'b1;
            end else if (ex_redir_s) begin
                id_flush_s = 1'b1;
                ie_flush_s = 1'b1;
            end else if (loaduse_s) begin
                id_stall_s = 1'b1;
                ie_flush_s = 1'b1;
            end else begin
                id_stall_s = 1'b0;
            end
            if (state_r == WAIT_ACK) begin
                id_flush_s        = 1'b1;
                redirect_valid_s  = 1'b1;
                redirect_target_s = bus.ls_redirect ? bus.ls_target : tgt_r;
            end else if (redir_event_s) begin
                redirect_valid_s  = 1'b1;
                redirect_target_s = sel_target_s;
            end else begin
                redirect_valid_s  = 1'b0;
            end
        end
        set_mask_s = '0;
        if (ex_load_s & ~ex_stall_s & ~ls_flush_s) begin
            set_mask_s = reg_mask(bus.ex_rd);
        end else begin
            set_mask_s = '0;
        end
    end

    // Pending-load scoreboard; a simultaneous set beats the writeback clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r <= '0;
        end else if (bus.ls_redirect) begin
            pend_r <= '0;
        end else begin
            pend_r <= (pend_r & ~clr_mask_s) | set_mask_s;
        end
    end

    // Redirect handshake FSM holding the target until fetch accepts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            tgt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (redir_event_s && !bus.if_redirect_ready) begin
                        state_r <= WAIT_ACK;
                        tgt_r   <= sel_target_s;
                    end
                end
                WAIT_ACK: begin
                    if (bus.ls_redirect) begin
                        tgt_r <= bus.ls_target;
                    end
                    if (bus.if_redirect_ready) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.redirect_valid  = redirect_valid_s;
    assign bus.redirect_target = redirect_target_s;
    assign bus.id_stall        = id_stall_s;
    assign bus.ex_stall        = ex_stall_s;
    assign bus.ls_stall        = ls_stall_s;
    assign bus.id_flush        = id_flush_s;
    assign bus.ie_flush        = ie_flush_s;
    assign bus.ls_flush        = ls_flush_s;

`ifdef YSYX_25060170_PIPE_PERF_EN
    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt    <= 32'd0;
            perf_loaduse_cnt  <= 32'd0;
            perf_redirect_cnt <= 32'd0;
        end else begin
            perf_stall_cnt    <= perf_stall_cnt + {31'd0, id_stall_s};
            perf_loaduse_cnt  <= perf_loaduse_cnt + {31'd0, loaduse_s};
            perf_redirect_cnt <= perf_redirect_cnt +
                                 {31'd0, redirect_valid_s & bus.if_redirect_ready};
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_25060170_pipe_ctrl.sv
// Directed bench for the pipe controller: expectations are queued per step and checked mid-cycle.
module tb_ysyx_25060170_pipe_ctrl;

    logic clk;
    logic rst;

    ysyx_25060170_pipe_ctrl_if b ();

`ifdef YSYX_25060170_PIPE_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_loaduse_cnt;
    logic [31:0] perf_redirect_cnt;
`endif

    ysyx_25060170_pipe_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
`ifdef YSYX_25060170_PIPE_PERF_EN
        ,
        .perf_stall_cnt    (perf_stall_cnt),
        .perf_loaduse_cnt  (perf_loaduse_cnt),
        .perf_redirect_cnt (perf_redirect_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rv;
        logic [31:0] tgt;
        logic        ids;
        logic        exs;
        logic        lss;
        logic        idf;
        logic        ief;
        logic        lsf;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    function automatic exp_t mk(string name, logic rv, logic [31:0] tgt,
                                logic ids, logic exs, logic lss,
                                logic idf, logic ief, logic lsf);
        exp_t e;
        e.name = name; e.rv = rv; e.tgt = tgt;
        e.ids = ids; e.exs = exs; e.lss = lss;
        e.idf = idf; e.ief = ief; e.lsf = lsf;
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic compare_head();
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, ".redirect_valid"},  {31'd0, b.redirect_valid}, {31'd0, e.rv});
        chk({e.name, ".redirect_target"}, b.redirect_target, e.tgt);
        chk({e.name, ".id_stall"}, {31'd0, b.id_stall}, {31'd0, e.ids});
        chk({e.name, ".ex_stall"}, {31'd0, b.ex_stall}, {31'd0, e.exs});
        chk({e.name, ".ls_stall"}, {31'd0, b.ls_stall}, {31'd0, e.lss});
        chk({e.name, ".id_flush"}, {31'd0, b.id_flush}, {31'd0, e.idf});
        chk({e.name, ".ie_flush"}, {31'd0, b.ie_flush}, {31'd0, e.ief});
        chk({e.name, ".ls_flush"}, {31'd0, b.ls_flush}, {31'd0, e.lsf});
    endtask

    // Inputs are set just after a falling edge; outputs are sampled 2 time units later.
    task automatic step(exp_t e);
        exp_q.push_back(e);
        #2;
        compare_head();
        @(negedge clk);
    endtask

    task automatic clr();
        rst                 = 1'b0;
        b.id_valid          = 1'b0;
        b.id_rs1            = 5'd0;
        b.id_rs1_en         = 1'b0;
        b.id_rs2            = 5'd0;
        b.id_rs2_en         = 1'b0;
        b.ex_valid          = 1'b0;
        b.ex_is_load        = 1'b0;
        b.ex_rd             = 5'd0;
        b.ex_redirect       = 1'b0;
        b.ex_target         = 32'd0;
        b.ls_busy           = 1'b0;
        b.ls_redirect       = 1'b0;
        b.ls_target         = 32'd0;
        b.wb_load_valid     = 1'b0;
        b.wb_rd             = 5'd0;
        b.if_redirect_ready = 1'b0;
    endtask

    task automatic ex_load(logic [4:0] rd);
        b.ex_valid   = 1'b1;
        b.ex_is_load = 1'b1;
        b.ex_rd      = rd;
    endtask

    task automatic id_rs1(logic [4:0] r);
        b.id_valid  = 1'b1;
        b.id_rs1    = r;
        b.id_rs1_en = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk    = 1'b0;

        // Reset with hazardous stimulus applied: everything must read zero.
        clr();
        rst = 1'b1;
        b.ex_redirect = 1'b1; b.ex_target = 32'h0000_1234;
        id_rs1(5'd5); ex_load(5'd5); b.ls_busy = 1'b1;
        step(mk("reset", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        clr();
        step(mk("post_reset", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        clr(); id_rs1(5'd5);
        step(mk("pend_zero", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Load-use on x5: EX match, then scoreboard, then WB bypass releases.
        clr(); id_rs1(5'd5); ex_load(5'd5);
        step(mk("lu_ex", 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        clr(); id_rs1(5'd5);
        step(mk("lu_pend1", 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        clr(); id_rs1(5'd5);
        step(mk("lu_pend2", 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        clr(); id_rs1(5'd5); b.wb_load_valid = 1'b1; b.wb_rd = 5'd5;
        step(mk("lu_bypass", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        clr(); id_rs1(5'd5);
        step(mk("lu_cleared", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        // x0 never hazards.
        clr(); id_rs1(5'd0); b.id_rs2 = 5'd0; b.id_rs2_en = 1'b1; ex_load(5'd0);
        step(mk("x0_ex", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        clr(); id_rs1(5'd0);
        step(mk("x0_after", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        // rs2 path, disabled-read boundary, and set-beats-clear on x7.
        clr(); ex_load(5'd7); b.id_valid = 1'b1; b.id_rs2 = 5'd7; b.id_rs2_en = 1'b0;
        step(mk("rs2_noen", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        clr(); b.id_valid = 1'b1; b.id_rs2 = 5'd7; b.id_rs2_en = 1'b1;
        step(mk("rs2_pend", 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        clr(); ex_load(5'd7); b.wb_load_valid = 1'b1; b.wb_rd = 5'd7;
        step(mk("setclr", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        clr(); b.id_valid = 1'b1; b.id_rs2 = 5'd7; b.id_rs2_en = 1'b1;
        step(mk("set_wins", 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        clr(); b.id_valid = 1'b1; b.id_rs2 = 5'd7; b.id_rs2_en = 1'b1;
        b.wb_load_valid = 1'b1; b.wb_rd = 5'd7;
        step(mk("rs2_bypass", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        // EX redirect held two cycles before fetch accepts.
        clr(); b.ex_redirect = 1'b1; b.ex_target = 32'h8000_0100;
        step(mk("exr_c1", 1'b1, 32'h8000_0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
        clr(); b.ex_redirect = 1'b1; b.ex_target = 32'hDEAD_BEEF;
        step(mk("exr_c2", 1'b1, 32'h8000_0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        clr(); b.if_redirect_ready = 1'b1;
        step(mk("exr_c3", 1'b1, 32'h8000_0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        clr();
        step(mk("exr_idle", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        // LS trap replaces a waiting redirect and wipes the scoreboard.
        clr(); ex_load(5'd9);
        step(mk("lsr_load", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        clr(); b.ex_redirect = 1'b1; b.ex_target = 32'h8000_0200;
        step(mk("lsr_exr", 1'b1, 32'h8000_0200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
        clr(); b.ls_redirect = 1'b1; b.ls_target = 32'h8000_0004; id_rs1(5'd9);
        step(mk("lsr_replace", 1'b1, 32'h8000_0004, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
        clr(); b.if_redirect_ready = 1'b1; id_rs1(5'd9);
        step(mk("lsr_ack", 1'b1, 32'h8000_0004, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        clr();
        step(mk("lsr_idle", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        // LSU busy freezes everything and masks the EX redirect.
        clr(); b.ls_busy = 1'b1; b.ex_redirect = 1'b1; b.ex_target = 32'h8000_0300;
        step(mk("busy_exr", 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        clr();
        step(mk("busy_after", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        clr(); b.ls_busy = 1'b1; ex_load(5'd11);
        step(mk("busy_load", 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        clr(); id_rs1(5'd11);
        step(mk("busy_noset", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Simultaneous redirects with immediate accept: LS wins, no wait state.
        clr(); b.ex_redirect = 1'b1; b.ex_target = 32'h8000_0400;
        b.ls_redirect = 1'b1; b.ls_target = 32'h8000_0008; b.if_redirect_ready = 1'b1;
        step(mk("prio_acc", 1'b1, 32'h8000_0008, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
        clr();
        step(mk("prio_idle", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Reset while waiting drops the request and the scoreboard.
        clr(); ex_load(5'd3);
        step(mk("rw_load", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        clr(); b.ex_redirect = 1'b1; b.ex_target = 32'h8000_0500;
        step(mk("rw_exr", 1'b1, 32'h8000_0500, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
        clr(); rst = 1'b1;
        step(mk("rw_rst", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        clr(); id_rs1(5'd3);
        step(mk("rw_after", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_25060170_pipe_ctrl.md
Name: ysyx_25060170_pipe_ctrl

Overview:
- Central hazard and redirect controller for the 5-stage core (IF, ID, EX, LS, WB).
- Generates stall and flush controls for the IF/ID, ID/EX and EX/LS pipeline registers.
- Tracks in-flight loads in a register scoreboard for load-use detection.
- Sequences PC redirects (EX branch mispredict, LS trap) to fetch, holding each request until fetch accepts it.

Parameters:
REG_NUM, 32, number of architectural registers tracked by the scoreboard
REG_AW, 5, register index width
PC_W, 32, PC / redirect target width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
id_valid  in  1  ID holds a valid instruction
id_rs1  in  REG_AW  ID source 1 index
id_rs1_en  in  1  ID reads rs1
id_rs2  in  REG_AW  ID source 2 index
id_rs2_en  in  1  ID reads rs2
ex_valid  in  1  EX holds a valid instruction
ex_is_load  in  1  EX instruction is a load
ex_rd  in  REG_AW  EX destination register
ex_redirect  in  1  EX branch/jump mispredict
ex_target  in  PC_W  EX redirect target
ls_busy  in  1  LSU waiting on memory
ls_redirect  in  1  LS trap/exception redirect
ls_target  in  PC_W  LS redirect target
wb_load_valid  in  1  load result written back this cycle
wb_rd  in  REG_AW  writeback destination
if_redirect_ready  in  1  fetch accepts redirect this cycle
redirect_valid  out  1  redirect request to fetch
redirect_target  out  PC_W  redirect PC
id_stall  out  1  hold IF/ID and the PC
ex_stall  out  1  hold ID/EX
ls_stall  out  1  hold EX/LS
id_flush  out  1  clear IF/ID to a bubble
ie_flush  out  1  clear ID/EX to a bubble
ls_flush  out  1  clear EX/LS to a bubble

Behaviour:
- Reset: FSM = IDLE, scoreboard = 0, latched target = 0. All outputs are 0 while rst is high.
- Register x0 is never marked pending and never causes a hazard.
- Scoreboard set: bit ex_rd is set when all hold: ex_valid & ex_is_load & ex_rd != 0 & ~ex_stall & ~ls_flush.
- Scoreboard clear: bit wb_rd is cleared when wb_load_valid.
- Same register set and cleared in one cycle: set wins.
- ls_redirect clears the whole scoreboard.
- Hazard check: pend_eff = pend & ~(wb_load_valid clear mask). A WB→ID bypass exists.
- Load-use hazard on rsN: id_valid & rsN_en & rsN != 0 & (pend_eff[rsN] | (ex_valid & ex_is_load & ex_rd == rsN)).
- ls_busy: asserts ls_stall, ex_stall and id_stall. No flush is issued. ex_redirect is ignored that cycle (EX is frozen).
- Load-use hazard (and not ls_busy): asserts id_stall and ie_flush (bubble into EX).
- Redirect priority: ls_redirect > ex_redirect.
  - ls_redirect asserts id_flush, ie_flush and ls_flush. It overrides all stalls except that the LS stage itself retires.
  - ex_redirect asserts id_flush and ie_flush.
- FSM IDLE:
  - A redirect event in cycle N drives redirect_valid = 1 and redirect_target = the selected target combinationally in cycle N.
  - If if_redirect_ready is high in cycle N, stay IDLE.
  - Otherwise latch the target and go to WAIT_ACK.
- FSM WAIT_ACK:
  - redirect_valid = 1 with the latched target.
  - id_flush = 1 every cycle, discarding wrong-path fetches.
  - A new ls_redirect replaces the latched target and is driven the same cycle.
  - ex_redirect is ignored.
  - Return to IDLE in the cycle after if_redirect_ready = 1.
- Flush/stall outputs are combinational from the current inputs and state. redirect_target in WAIT_ACK comes from a register.
- Reset mid-WAIT_ACK: the request is dropped and the FSM returns to IDLE.

Optional Feature:
YSYX_25060170_PIPE_PERF_EN
- Defined: adds 32-bit output ports perf_stall_cnt, perf_loaduse_cnt and perf_redirect_cnt.
  - perf_stall_cnt increments on cycles with id_stall.
  - perf_loaduse_cnt increments on cycles with a load-use hazard.
  - perf_redirect_cnt increments once per accepted redirect.
  - All three reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent. Core behaviour is identical.

Test Plan:
- Load to x5 in EX, ID reads rs1 = x5 → id_stall = 1, ie_flush = 1 that cycle. The load leaves EX and pend[5] = 1. Stall persists until the cycle wb_load_valid with wb_rd = 5, when id_stall = 0.
- Load to x0 in EX, ID reads x0 → no stall; pend remains 0.
- ex_redirect, target 0x8000_0100, if_redirect_ready = 0 for 2 cycles then 1 → redirect_valid high for 3 cycles with 0x8000_0100. id_flush is high in all 3 cycles. IDLE follows.
- In WAIT_ACK, ls_redirect with target 0x8000_0004 → redirect_target = 0x8000_0004 the same cycle. ls_flush = 1 and the scoreboard is cleared.
- ls_busy = 1 together with ex_redirect → all stalls = 1, no flush, redirect_valid = 0.
- rst asserted during WAIT_ACK → next cycle redirect_valid = 0, FSM = IDLE, pend = 0.
